// File: rtl/branch_pkg.sv
// ============================================================================
// Module      : branch_pkg
// Description : Shared funct3 codes, FSM state encoding and decode helpers
//               for branch_resolve_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // 2'd3 is unused and is treated as IDLE by the controller
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3[2:1] == 2'b01);
    endfunction

    function automatic logic f3_taken(input logic [2:0] f3, input logic eq, input logic lt);
        logic t;
        t = 1'b0;
        case (f3)
            F3_BEQ:           t = eq;
            F3_BNE:           t = !eq;
            F3_BLT, F3_BLTU:  t = lt;
            F3_BGE, F3_BGEU:  t = !lt;
            default:          t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_comp.sv
// ============================================================================
// Module      : branch_comp
// Description : Shared 32-bit branch comparator; cmpop=1 selects unsigned.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_comp (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cmpop,
    output logic        br_eq,
    output logic        br_lt
);

    assign br_eq = (a == b);
    assign br_lt = cmpop ? (a < b) : ($signed(a) < $signed(b));

endmodule

`default_nettype wire

// File: rtl/branch_resolve_ctrl.sv
// ============================================================================
// Module      : branch_resolve_ctrl
// Description : IDLE/CMP/RESP sequencer around branch_comp that resolves
//               conditional branches and returns the redirect PC.
//               Define BRANCH_STATS_EN to build the branch statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve_ctrl
    import branch_pkg::*;
#(
    parameter int XLEN   = 32,   // branch_comp is fixed 32-bit
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_rs1,
    input  logic [XLEN-1:0]   req_rs2,
    input  logic [XLEN-1:0]   req_pc,
    input  logic [XLEN-1:0]   req_imm,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_taken,
    output logic [XLEN-1:0]   rsp_target,
    output logic              rsp_illegal,
    output logic [STAT_W-1:0] stat_total,
    output logic [STAT_W-1:0] stat_taken
);

    state_e            state_q, state_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, pc_q, pc_d, imm_q, imm_d;
    logic              taken_q, taken_d, illegal_q, illegal_d;
    logic [XLEN-1:0]   target_q, target_d;
    logic              br_eq, br_lt;

    branch_comp u_branch_comp (
        .a     (rs1_q),
        .b     (rs2_q),
        .cmpop (f3_q[1]),
        .br_eq (br_eq),
        .br_lt (br_lt)
    );

    always_comb begin
        state_d   = state_q;
        f3_d      = f3_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        pc_d      = pc_q;
        imm_d     = imm_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;
        target_d  = target_q;
        case (state_q)
            CMP: begin
                taken_d   = f3_taken(f3_q, br_eq, br_lt);
                illegal_d = f3_illegal(f3_q);
                target_d  = taken_d ? (pc_q + imm_q) : (pc_q + XLEN'(4));
                state_d   = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: begin
                if (req_valid && !flush) begin
                    f3_d    = req_funct3;
                    rs1_d   = req_rs1;
                    rs2_d   = req_rs2;
                    pc_d    = req_pc;
                    imm_d   = req_imm;
                    state_d = CMP;
                end
            end
        endcase
        // A squashed branch leaves the previous response values untouched
        if (flush) begin
            state_d   = IDLE;
            taken_d   = taken_q;
            illegal_d = illegal_q;
            target_d  = target_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            f3_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            pc_q      <= '0;
            imm_q     <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            target_q  <= '0;
        end else begin
            state_q   <= state_d;
            f3_q      <= f3_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            pc_q      <= pc_d;
            imm_q     <= imm_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
            target_q  <= target_d;
        end
    end

    assign req_ready   = (state_q != CMP) && (state_q != RESP);
    assign rsp_valid   = (state_q == RESP);
    assign rsp_taken   = taken_q;
    assign rsp_illegal = illegal_q;
    assign rsp_target  = target_q;

`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] stat_total_q, stat_total_d, stat_taken_q, stat_taken_d;

    always_comb begin
        stat_total_d = stat_total_q;
        stat_taken_d = stat_taken_q;
        if (rsp_valid && rsp_ready && !flush) begin
            stat_total_d = stat_total_q + STAT_W'(1);
            if (taken_q) stat_taken_d = stat_taken_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_total_q <= '0;
            stat_taken_q <= '0;
        end else begin
            stat_total_q <= stat_total_d;
            stat_taken_q <= stat_taken_d;
        end
    end

    assign stat_total = stat_total_q;
    assign stat_taken = stat_taken_q;
`else
    assign stat_total = '0;
    assign stat_taken = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_ctrl.sv
// ============================================================================
// Module      : tb_branch_resolve_ctrl
// Description : Directed self-checking bench for branch_resolve_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve_ctrl;

`ifdef BRANCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, req_valid, req_ready, rsp_valid, rsp_ready;
    logic        rsp_taken, rsp_illegal;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1, req_rs2, req_pc, req_imm, rsp_target;
    logic [31:0] stat_total, stat_taken;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.XLEN(32), .STAT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_funct3  (req_funct3),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_pc      (req_pc),
        .req_imm     (req_imm),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_taken   (rsp_taken),
        .rsp_target  (rsp_target),
        .rsp_illegal (rsp_illegal),
        .stat_total  (stat_total),
        .stat_taken  (stat_taken)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Presents a request for one edge, then checks the CMP-cycle handshake state
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm);
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_rs1    = a;
        req_rs2    = b;
        req_pc     = pc;
        req_imm    = imm;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        chk("cmp_req_ready", 32'(req_ready), 32'd0);
        chk("cmp_rsp_valid", 32'(rsp_valid), 32'd0);
    endtask

    task automatic resolve(input string tag, input logic exp_taken, input logic exp_illegal,
                           input logic [31:0] exp_target);
        @(posedge clk); #1;
        chk({tag, "_valid"},   32'(rsp_valid),   32'd1);
        chk({tag, "_taken"},   32'(rsp_taken),   32'(exp_taken));
        chk({tag, "_illegal"}, 32'(rsp_illegal), 32'(exp_illegal));
        chk({tag, "_target"},  rsp_target,       exp_target);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_done_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_funct3 = 3'b000; req_rs1 = '0; req_rs2 = '0; req_pc = '0; req_imm = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready",  32'(req_ready),   32'd1);
        chk("rst_rsp_valid",  32'(rsp_valid),   32'd0);
        chk("rst_rsp_taken",  32'(rsp_taken),   32'd0);
        chk("rst_rsp_illegal",32'(rsp_illegal), 32'd0);
        chk("rst_rsp_target", rsp_target,       32'd0);
        chk("rst_stat_total", stat_total,       32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // BEQ equal operands
        issue(3'b000, 32'h5, 32'h5, 32'h100, 32'h20);
        resolve("beq", 1'b1, 1'b0, 32'h120);

        // signed vs unsigned ordering of -1 and 1
        issue(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40);
        resolve("blt", 1'b1, 1'b0, 32'h240);
        issue(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40);
        resolve("bltu", 1'b0, 1'b0, 32'h204);
        chk("stat_total_3", stat_total, STATS ? 32'd3 : 32'd0);
        chk("stat_taken_2", stat_taken, STATS ? 32'd2 : 32'd0);

        // reserved funct3
        issue(3'b010, 32'h7, 32'h7, 32'h300, 32'h80);
        resolve("ill010", 1'b0, 1'b1, 32'h304);

        // backpressure: held response stays stable
        issue(3'b001, 32'h1, 32'h2, 32'h400, 32'h10);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_valid",  32'(rsp_valid), 32'd1);
            chk("hold_taken",  32'(rsp_taken), 32'd1);
            chk("hold_target", rsp_target,     32'h410);
            chk("hold_ready",  32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("hold_rel_valid", 32'(rsp_valid), 32'd0);
        chk("hold_rel_ready", 32'(req_ready), 32'd1);

        // request presented together with flush is ignored
        flush = 1'b1; req_valid = 1'b1; req_funct3 = 3'b000;
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        chk("flushreq_ready", 32'(req_ready), 32'd1);

        // flush while comparing
        issue(3'b101, 32'h3, 32'h9, 32'h500, 32'h8);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_valid", 32'(rsp_valid), 32'd0);
        chk("flush_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        chk("flush_valid2", 32'(rsp_valid), 32'd0);
        chk("flush_stat_total", stat_total, STATS ? 32'd5 : 32'd0);
        chk("flush_stat_taken", stat_taken, STATS ? 32'd3 : 32'd0);

        // BGE signed: most-negative < 0
        issue(3'b101, 32'h8000_0000, 32'h0, 32'h600, 32'h100);
        resolve("bge", 1'b0, 1'b0, 32'h604);

        // target wraps modulo 2^32
        issue(3'b111, 32'h5, 32'h5, 32'hFFFF_FFF0, 32'h20);
        resolve("bgeu_wrap", 1'b1, 1'b0, 32'h10);
        chk("stat_total_end", stat_total, STATS ? 32'd7 : 32'd0);
        chk("stat_taken_end", stat_taken, STATS ? 32'd4 : 32'd0);

        // reset while holding a response
        issue(3'b000, 32'h9, 32'h9, 32'h700, 32'h44);
        @(posedge clk); #1;
        chk("prerst_valid", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstresp_valid",  32'(rsp_valid),   32'd0);
        chk("rstresp_taken",  32'(rsp_taken),   32'd0);
        chk("rstresp_target", rsp_target,       32'd0);
        chk("rstresp_ready",  32'(req_ready),   32'd1);
        chk("rstresp_total",  stat_total,       32'd0);
        chk("rstresp_staken", stat_taken,       32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
